// File: rtl/pc_sequencer_if.sv
// Fetch-stage redirect controls and program-counter / return-stack status.
// master drives the controls (decode/execute); slave is the sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             w_enable;
  logic             br_taken;
  logic [WIDTH-1:0] br_offset;
  logic             jmp;
  logic             call;
  logic [WIDTH-1:0] jmp_target;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_err;

  modport master (
    output w_enable, br_taken, br_offset, jmp, call, jmp_target, ret,
    input  pc, pc_next, ras_empty, ras_full, ras_ovf, ras_err
  );

  modport slave (
    input  w_enable, br_taken, br_offset, jmp, call, jmp_target, ret,
    output pc, pc_next, ras_empty, ras_full, ras_ovf, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with branch/jump/call/return and a circular return-address stack.
// pc updates one edge after controls are sampled; w_enable=0 stalls all state.
module pc_sequencer #(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  localparam int               PW       = $clog2(RAS_DEPTH);
  localparam int               CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    top_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             err_q;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] nxt;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign seq_pc  = pc_q + STEP_W;
  assign top_inc = top_q + 1'b1;
  assign top_dec = top_q - 1'b1;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  // ret takes precedence over call, so a ret cycle never pushes
  assign push    = bus.w_enable & ~bus.ret & bus.call;
  assign pop     = bus.w_enable & bus.ret;

  always_comb begin
    nxt = seq_pc;
    if (bus.ret) begin
      if (!empty) nxt = ras_q[top_q];
    end else if (bus.call || bus.jmp) begin
      nxt = bus.jmp_target;
    end else if (bus.br_taken) begin
      nxt = pc_q + bus.br_offset;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (bus.w_enable) begin
      pc_q <= nxt;
      if (push) begin
        // when full, top_inc lands on the oldest entry and overwrites it
        top_q          <= top_inc;
        ras_q[top_inc] <= seq_pc;
        if (full) ovf_q <= 1'b1;
        else      cnt_q <= cnt_q + 1'b1;
      end else if (pop) begin
        if (empty) begin
          err_q <= 1'b1;
        end else begin
          top_q <= top_dec;
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_next   = nxt;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer (WIDTH=16, STEP=2, RESET_VEC=0, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(16)) bus ();

  pc_sequencer #(
    .WIDTH    (16),
    .STEP     (2),
    .RESET_VEC(16'h0000),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // flags packed as {ras_empty, ras_full, ras_ovf, ras_err}
  typedef struct {
    logic        w;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic        call;
    logic [15:0] tgt;
    logic        ret;
    logic [15:0] epc;
    logic [15:0] enxt;
    logic [3:0]  eflg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic w, input logic br, input logic [15:0] off,
                     input logic jmp, input logic call, input logic [15:0] tgt,
                     input logic ret, input logic [15:0] epc, input logic [15:0] enxt,
                     input logic [3:0] eflg);
    vec_t v;
    v.w = w; v.br = br; v.off = off; v.jmp = jmp; v.call = call; v.tgt = tgt;
    v.ret = ret; v.epc = epc; v.enxt = enxt; v.eflg = eflg;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.w_enable   = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_offset  = 16'h0000;
    bus.jmp        = 1'b0;
    bus.call       = 1'b0;
    bus.jmp_target = 16'h0000;
    bus.ret        = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_err};
  endfunction

  initial begin
    //   w  br off       jmp call tgt      ret  pc       pc_next  flags
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 16'h0002, 4'b1000);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0004, 16'h0004, 4'b1000);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0006, 16'h0006, 4'b1000);
    add(0, 1, 16'h0008, 0, 0, 16'h0000, 0, 16'h0006, 16'h000E, 4'b1000);
    add(0, 1, 16'h0008, 0, 0, 16'h0000, 0, 16'h0006, 16'h000E, 4'b1000);
    add(1, 1, 16'h0008, 0, 0, 16'h0000, 0, 16'h000E, 16'h000E, 4'b1000);
    add(1, 1, 16'hFFF8, 0, 0, 16'h0000, 0, 16'h0006, 16'h0006, 4'b1000);
    add(1, 1, 16'hFFFC, 0, 0, 16'h0000, 0, 16'h0002, 16'h0002, 4'b1000);
    add(1, 0, 16'h0000, 1, 0, 16'hFFFE, 0, 16'hFFFE, 16'hFFFE, 4'b1000);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 4'b1000);
    add(1, 0, 16'h0000, 1, 0, 16'h0010, 0, 16'h0010, 16'h0010, 4'b1000);
    add(1, 0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0100, 16'h0100, 4'b0000);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0012, 16'h0012, 4'b1000);
    add(1, 0, 16'h0000, 1, 0, 16'h0010, 0, 16'h0010, 16'h0010, 4'b1000);
    add(1, 0, 16'h0000, 0, 1, 16'h0020, 0, 16'h0020, 16'h0020, 4'b0000);
    add(1, 0, 16'h0000, 0, 1, 16'h0030, 0, 16'h0030, 16'h0030, 4'b0000);
    add(1, 0, 16'h0000, 0, 1, 16'h0040, 0, 16'h0040, 16'h0040, 4'b0000);
    add(1, 0, 16'h0000, 0, 1, 16'h0050, 0, 16'h0050, 16'h0050, 4'b0100);
    add(1, 0, 16'h0000, 0, 1, 16'h0060, 0, 16'h0060, 16'h0060, 4'b0110);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0052, 16'h0052, 4'b0010);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0042, 16'h0042, 4'b0010);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0032, 16'h0032, 4'b0010);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0022, 16'h0022, 4'b1010);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0024, 16'h0024, 4'b1011);
    add(1, 0, 16'h0000, 1, 1, 16'h0080, 0, 16'h0080, 16'h0080, 4'b0011);
    add(1, 0, 16'h0000, 1, 1, 16'h0090, 0, 16'h0090, 16'h0090, 4'b0011);
    add(1, 1, 16'h0100, 1, 1, 16'h0200, 1, 16'h0082, 16'h0082, 4'b0011);
    add(1, 1, 16'h0004, 1, 0, 16'h0300, 0, 16'h0300, 16'h0300, 4'b0011);
    add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0300, 16'h0026, 4'b0011);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0026, 16'h0026, 4'b1011);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0028, 16'h0028, 4'b1011);

    idle();
    #1;
    chk("reset pc", 32'(bus.pc), 32'h0000);
    chk("reset flags", 32'(flags()), 32'h8);

    // run two edges, then reset asynchronously between edges
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre-reset pc", 32'(bus.pc), 32'h0004);
    #2 rst = 1'b1;
    #1;
    chk("async reset pc", 32'(bus.pc), 32'h0000);
    chk("async reset flags", 32'(flags()), 32'h8);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bus.w_enable   = vq[i].w;
      bus.br_taken   = vq[i].br;
      bus.br_offset  = vq[i].off;
      bus.jmp        = vq[i].jmp;
      bus.call       = vq[i].call;
      bus.jmp_target = vq[i].tgt;
      bus.ret        = vq[i].ret;
      #2;
      chk($sformatf("v%0d pc_next", i), 32'(bus.pc_next), 32'(vq[i].enxt));
      @(posedge clk); #1;
      chk($sformatf("v%0d pc", i), 32'(bus.pc), 32'(vq[i].epc));
      chk($sformatf("v%0d flags", i), 32'(flags()), 32'(vq[i].eflg));
    end

    // sticky flags are set here; an asynchronous reset must clear them and the stack
    idle();
    #3 rst = 1'b1;
    #1;
    chk("final reset pc", 32'(bus.pc), 32'h0000);
    chk("final reset flags", 32'(flags()), 32'h8);
    @(posedge clk); #1;
    chk("reset holds pc", 32'(bus.pc), 32'h0000);
    rst = 1'b0;
    bus.ret = 1'b1;
    #2;
    chk("ret after reset pc_next", 32'(bus.pc_next), 32'h0002);
    @(posedge clk); #1;
    chk("ret after reset flags", 32'(flags()), 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
